// File: rtl/parity_mem.sv
// -----------------------------------------------------------------------------
// parity_mem
//
// Small fully-associative tag/data table with per-word even parity.
// Each entry holds {valid, tag, data, p}. Writes either update a matching
// entry in place or allocate the lowest-index free entry. When the table is
// full, a write to a new address is discarded and flagged. Reads look up the
// address in all valid entries at once and return data, a miss flag and a
// parity-error flag one cycle later. Entries are only freed by reset.
//
// Parameters
//   DATA_W   data bits per word
//   ADDR_W   tag/address width
//   DEPTH    number of entries (power of 2, >= 2)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   write       write request
//   read        read request (ignored when write is also high)
//   address     access address
//   data_in     write data
//   inj_err     with write: store inverted parity (error injection)
//   data_out    read data (held while rd_valid is low)
//   rd_valid    one-cycle pulse qualifying data_out / parity_err / miss
//   parity_err  read word failed its parity check
//   miss        read address held no entry
//   wr_drop     one-cycle pulse: write discarded because the table was full
//   full        all entries valid
//   count       number of valid entries
// -----------------------------------------------------------------------------
module parity_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     inj_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     parity_err,
  output logic                     miss,
  output logic                     wr_drop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Table state
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  par_q;
  logic [CNT_W-1:0]  count_q, count_d;

  // Goes high on the first clock edge after reset release; the access
  // sampled on that edge is ignored so nothing races the deassertion.
  logic active_q;

  // Lookup / control
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en, rd_en;
  logic             wr_hit, wr_alloc, wr_drop_d;

  // Read response
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_miss_d, rd_perr_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q, parity_err_q, miss_q, wr_drop_q;

  // Parallel tag compare. Allocation never creates a duplicate tag, so at
  // most one entry can match.
  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == address)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index free entry: scan downwards so the last assignment wins.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign wr_en     = active_q & write;
  assign rd_en     = active_q & read & ~write;   // write has priority
  assign wr_hit    = wr_en & hit;
  assign wr_alloc  = wr_en & ~hit & ~full;
  assign wr_drop_d = wr_en & ~hit & full;
  assign wr_idx    = wr_hit ? hit_idx : free_idx;

  always_comb begin
    valid_d = valid_q;
    if (wr_alloc) begin
      valid_d[free_idx] = 1'b1;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, wr_alloc};
  end

  // Read response computed from the current table contents; a write on the
  // previous edge is already committed, so read-after-write sees new data.
  always_comb begin
    rd_data_d = data_q[hit_idx];
    rd_miss_d = ~hit;
    rd_perr_d = (^data_q[hit_idx]) ^ par_q[hit_idx];
    if (!hit) begin
      rd_data_d = '0;
      rd_perr_d = 1'b0;
    end
  end

  // Control state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= 1'b0;
      valid_q      <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      miss_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      active_q   <= 1'b1;
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_valid_q <= rd_en;
      wr_drop_q  <= wr_drop_d;
      if (rd_en) begin
        data_out_q   <= rd_data_d;
        miss_q       <= rd_miss_d;
        parity_err_q <= rd_perr_d;
      end
    end
  end

  // Tag/data/parity storage.
  // NOTE: storage arrays are not reset; the valid bits gate every use of
  // them, so clearing valid_q is sufficient and keeps the array reset-free.
  always_ff @(posedge clk) begin
    if (wr_hit || wr_alloc) begin
      tag_q[wr_idx]  <= address;
      data_q[wr_idx] <= data_in;
      par_q[wr_idx]  <= (^data_in) ^ inj_err;
    end
  end

  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign parity_err = parity_err_q;
  assign miss       = miss_q;
  assign wr_drop    = wr_drop_q;
  assign count      = count_q;

endmodule

// File: tb/tb_parity_mem.sv
// -----------------------------------------------------------------------------
// tb_parity_mem
//
// Directed testbench for parity_mem with the default parameters
// (DATA_W=8, ADDR_W=16, DEPTH=16). Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_parity_mem;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        inj_err;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic        parity_err;
  logic        miss;
  logic        wr_drop;
  logic        full;
  logic [4:0]  count;

  int passed = 0;
  int total  = 0;

  parity_mem #(.DATA_W(8), .ADDR_W(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .read       (read),
    .address    (address),
    .data_in    (data_in),
    .inj_err    (inj_err),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .parity_err (parity_err),
    .miss       (miss),
    .wr_drop    (wr_drop),
    .full       (full),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic inj);
    write = 1'b1; address = a; data_in = d; inj_err = inj;
    step();
    write = 1'b0; inj_err = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    read = 1'b1; address = a;
    step();
    read = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; data_in = '0; inj_err = 1'b0;
    step(); step();
    total++;
    if ({data_out, rd_valid, parity_err, miss, wr_drop, full, count} !== 18'd0)
      $display("FAIL reset_outputs: got dout=%h rv=%b pe=%b miss=%b drop=%b full=%b cnt=%0d, required all 0",
               data_out, rd_valid, parity_err, miss, wr_drop, full, count);
    else passed++;
    // Release reset together with a write: that edge's access is ignored.
    rst_n = 1'b1; write = 1'b1; address = 16'h5555; data_in = 8'h11;
    step();
    write = 1'b0;
    total++;
    if (count !== 5'd0) $display("FAIL release_write_ignored_count: got %0d required 0", count);
    else passed++;
    rd(16'h5555);
    total++;
    if (rd_valid !== 1'b1 || miss !== 1'b1)
      $display("FAIL release_write_ignored_read: got rv=%b miss=%b required rv=1 miss=1", rd_valid, miss);
    else passed++;
  endtask

  task automatic test_basic();
    wr(16'h1234, 8'hA5, 1'b0);
    rd(16'h1234);
    total++;
    if (rd_valid !== 1'b1 || data_out !== 8'hA5 || miss !== 1'b0 || parity_err !== 1'b0 || count !== 5'd1)
      $display("FAIL basic_read: got rv=%b dout=%h miss=%b pe=%b cnt=%0d required rv=1 dout=a5 miss=0 pe=0 cnt=1",
               rd_valid, data_out, miss, parity_err, count);
    else passed++;
    step();
    total++;
    if (rd_valid !== 1'b0 || data_out !== 8'hA5 || miss !== 1'b0)
      $display("FAIL basic_hold: got rv=%b dout=%h miss=%b required rv=0 dout=a5 miss=0", rd_valid, data_out, miss);
    else passed++;
  endtask

  task automatic test_miss();
    rd(16'hBEEF);
    total++;
    if (rd_valid !== 1'b1 || miss !== 1'b1 || data_out !== 8'h00 || parity_err !== 1'b0 || count !== 5'd1)
      $display("FAIL read_miss: got rv=%b miss=%b dout=%h pe=%b cnt=%0d required rv=1 miss=1 dout=00 pe=0 cnt=1",
               rd_valid, miss, data_out, parity_err, count);
    else passed++;
  endtask

  task automatic test_parity();
    wr(16'h0010, 8'h3C, 1'b1);
    rd(16'h0010);
    total++;
    if (rd_valid !== 1'b1 || data_out !== 8'h3C || parity_err !== 1'b1 || miss !== 1'b0)
      $display("FAIL parity_inject: got rv=%b dout=%h pe=%b miss=%b required rv=1 dout=3c pe=1 miss=0",
               rd_valid, data_out, parity_err, miss);
    else passed++;
    wr(16'h0010, 8'h3C, 1'b0);
    rd(16'h0010);
    total++;
    if (rd_valid !== 1'b1 || data_out !== 8'h3C || parity_err !== 1'b0 || count !== 5'd2)
      $display("FAIL parity_clean: got rv=%b dout=%h pe=%b cnt=%0d required rv=1 dout=3c pe=0 cnt=2",
               rd_valid, data_out, parity_err, count);
    else passed++;
    // Odd-weight data with clean parity must also check clean.
    wr(16'h0011, 8'h07, 1'b0);
    rd(16'h0011);
    total++;
    if (data_out !== 8'h07 || parity_err !== 1'b0 || count !== 5'd3)
      $display("FAIL parity_odd_data: got dout=%h pe=%b cnt=%0d required dout=07 pe=0 cnt=3",
               data_out, parity_err, count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // Write and read together: write wins, no read response.
    write = 1'b1; read = 1'b1; address = 16'h0001; data_in = 8'h5A;
    step();
    write = 1'b0; read = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || count !== 5'd4)
      $display("FAIL wr_rd_same_cycle: got rv=%b cnt=%0d required rv=0 cnt=4", rd_valid, count);
    else passed++;
    rd(16'h0001);
    total++;
    if (rd_valid !== 1'b1 || data_out !== 8'h5A || miss !== 1'b0)
      $display("FAIL wr_rd_followup: got rv=%b dout=%h miss=%b required rv=1 dout=5a miss=0", rd_valid, data_out, miss);
    else passed++;
    // Overwrite in place, read immediately after.
    wr(16'h1234, 8'hC3, 1'b0);
    rd(16'h1234);
    total++;
    if (data_out !== 8'hC3 || count !== 5'd4)
      $display("FAIL overwrite_raw: got dout=%h cnt=%0d required dout=c3 cnt=4", data_out, count);
    else passed++;
  endtask

  task automatic test_async_reset();
    wr(16'h0A00, 8'h21, 1'b0);
    rd(16'h0001);  // leave non-zero data on data_out
    total++;
    if (count !== 5'd5 || data_out !== 8'h5A)
      $display("FAIL pre_reset_state: got cnt=%0d dout=%h required cnt=5 dout=5a", count, data_out);
    else passed++;
    // Read in flight, then reset asserted between clock edges.
    read = 1'b1; address = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({data_out, rd_valid, parity_err, miss, wr_drop, full, count} !== 18'd0)
      $display("FAIL async_reset_outputs: got dout=%h rv=%b pe=%b miss=%b drop=%b full=%b cnt=%0d required all 0",
               data_out, rd_valid, parity_err, miss, wr_drop, full, count);
    else passed++;
    step();
    read = 1'b0;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL reset_no_rd_valid: got %b required 0", rd_valid);
    else passed++;
    rst_n = 1'b1;
    step();
    begin
      logic [15:0] addrs [5];
      int misses;
      addrs = '{16'h1234, 16'h0010, 16'h0011, 16'h0001, 16'h0A00};
      misses = 0;
      for (int i = 0; i < 5; i++) begin
        rd(addrs[i]);
        if (rd_valid === 1'b1 && miss === 1'b1 && data_out === 8'h00) misses++;
      end
      total++;
      if (misses != 5 || count !== 5'd0)
        $display("FAIL reset_clears_table: got misses=%0d cnt=%0d required misses=5 cnt=0", misses, count);
      else passed++;
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) wr(16'h0100 + 16'(i), 8'(i + 1), 1'b0);
    total++;
    if (count !== 5'd15 || full !== 1'b0)
      $display("FAIL fifteen_entries: got cnt=%0d full=%b required cnt=15 full=0", count, full);
    else passed++;
    wr(16'h010F, 8'h10, 1'b0);
    total++;
    if (count !== 5'd16 || full !== 1'b1 || wr_drop !== 1'b0)
      $display("FAIL table_full: got cnt=%0d full=%b drop=%b required cnt=16 full=1 drop=0", count, full, wr_drop);
    else passed++;
    rd(16'h0107);
    total++;
    if (data_out !== 8'h08 || miss !== 1'b0)
      $display("FAIL full_read_mid: got dout=%h miss=%b required dout=08 miss=0", data_out, miss);
    else passed++;
    wr(16'hFFFF, 8'hEE, 1'b0);
    total++;
    if (wr_drop !== 1'b1 || count !== 5'd16)
      $display("FAIL drop_pulse: got drop=%b cnt=%0d required drop=1 cnt=16", wr_drop, count);
    else passed++;
    step();
    total++;
    if (wr_drop !== 1'b0) $display("FAIL drop_single_cycle: got %b required 0", wr_drop);
    else passed++;
    rd(16'hFFFF);
    total++;
    if (rd_valid !== 1'b1 || miss !== 1'b1 || data_out !== 8'h00)
      $display("FAIL dropped_addr_miss: got rv=%b miss=%b dout=%h required rv=1 miss=1 dout=00", rd_valid, miss, data_out);
    else passed++;
    wr(16'h0100, 8'h77, 1'b0);
    total++;
    if (wr_drop !== 1'b0 || count !== 5'd16)
      $display("FAIL full_write_hit: got drop=%b cnt=%0d required drop=0 cnt=16", wr_drop, count);
    else passed++;
    rd(16'h0100);
    total++;
    if (data_out !== 8'h77 || miss !== 1'b0 || parity_err !== 1'b0)
      $display("FAIL full_write_hit_read: got dout=%h miss=%b pe=%b required dout=77 miss=0 pe=0", data_out, miss, parity_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_parity();
    test_back_to_back();
    test_async_reset();
    test_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
